// File: rtl/arm_pkg.sv
// ==========================================================================
// arm_pkg : shared opcode, shift, forwarding and status-bit constants
// Rev 1.0
// ==========================================================================
`default_nettype none

package arm_pkg;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_MVN = 4'b1001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;

   localparam logic [1:0] SHIFT_LSL = 2'b00;
   localparam logic [1:0] SHIFT_LSR = 2'b01;
   localparam logic [1:0] SHIFT_ASR = 2'b10;
   localparam logic [1:0] SHIFT_ROR = 2'b11;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/val2_generator.sv
// ==========================================================================
// val2_generator : second ALU operand (memory offset, rotated imm, shifted Rm)
// Rev 1.0
// ==========================================================================
`default_nettype none

module val2_generator
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             imm,
   input  logic             mem_en,
   input  logic [11:0]      shift_operand,
   input  logic [WIDTH-1:0] rm,
   output logic [WIDTH-1:0] val2
);

   logic [4:0] shift_imm;
   logic [4:0] rot_amt;

   assign shift_imm = shift_operand[11:7];
   // Rotate field counts in pairs of bits
   assign rot_amt   = {shift_operand[11:8], 1'b0};

   always_comb begin
      val2 = rm;
      if (mem_en) begin
         val2 = {20'b0, shift_operand};
      end else if (imm) begin
         val2 = ror32({24'b0, shift_operand[7:0]}, rot_amt);
      end else begin
         case (shift_operand[6:5])
            SHIFT_LSL: val2 = rm << shift_imm;
            SHIFT_LSR: val2 = rm >> shift_imm;
            SHIFT_ASR: val2 = $signed(rm) >>> shift_imm;
            default:   val2 = ror32(rm, shift_imm);
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/exe_stage.sv
// ==========================================================================
// exe_stage : execute stage - forwarding, Val2, ALU, branch target, {N,Z,C,V}
// Rev 1.0
// ==========================================================================
`default_nettype none

module exe_stage
   import arm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SR_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic [3:0]       exe_cmd,
   input  logic             mem_r_en,
   input  logic             mem_w_en,
   input  logic             s,
   input  logic             imm,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] val_rn,
   input  logic [WIDTH-1:0] val_rm,
   input  logic [11:0]      shift_operand,
   input  logic [23:0]      signed_imm_24,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] mem_fwd,
   input  logic [WIDTH-1:0] wb_fwd,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] br_addr,
   output logic [WIDTH-1:0] st_val,
   output logic [SR_W-1:0]  status
);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_rm;
   logic [WIDTH-1:0] val2;
   logic [WIDTH:0]   sum;
   logic [SR_W-1:0]  next_flags;
   logic             c_in;
   logic             c_out;
   logic             v_out;
   logic             cmd_valid;

   always_comb begin
      case (sel_src1)
         FWD_MEM: op_a = mem_fwd;
         FWD_WB:  op_a = wb_fwd;
         default: op_a = val_rn;
      endcase
      case (sel_src2)
         FWD_MEM: op_rm = mem_fwd;
         FWD_WB:  op_rm = wb_fwd;
         default: op_rm = val_rm;
      endcase
   end

   assign st_val = op_rm;

   val2_generator #(
      .WIDTH (WIDTH)
   ) u_val2 (
      .imm           (imm),
      .mem_en        (mem_r_en | mem_w_en),
      .shift_operand (shift_operand),
      .rm            (op_rm),
      .val2          (val2)
   );

   assign c_in = status[SR_C];

   // Subtraction runs as A + ~B + 1 so the carry-out is directly NOT borrow
   always_comb begin
      sum        = '0;
      alu_result = '0;
      c_out      = status[SR_C];
      v_out      = 1'b0;
      cmd_valid  = 1'b1;
      case (exe_cmd)
         EXE_MOV: alu_result = val2;
         EXE_MVN: alu_result = ~val2;
         EXE_ADD, EXE_ADC: begin
            sum        = {1'b0, op_a} + {1'b0, val2}
                       + {{WIDTH{1'b0}}, (exe_cmd == EXE_ADC) & c_in};
            alu_result = sum[WIDTH-1:0];
            c_out      = sum[WIDTH];
            v_out      = (op_a[WIDTH-1] == val2[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != op_a[WIDTH-1]);
         end
         EXE_SUB, EXE_SBC: begin
            sum        = {1'b0, op_a} + {1'b0, ~val2}
                       + {{WIDTH{1'b0}}, (exe_cmd == EXE_SUB) | c_in};
            alu_result = sum[WIDTH-1:0];
            c_out      = sum[WIDTH];
            v_out      = (op_a[WIDTH-1] != val2[WIDTH-1]) &&
                         (alu_result[WIDTH-1] != op_a[WIDTH-1]);
         end
         EXE_AND: alu_result = op_a & val2;
         EXE_ORR: alu_result = op_a | val2;
         EXE_EOR: alu_result = op_a ^ val2;
         default: begin
            cmd_valid = 1'b0;
            c_out     = 1'b0;
         end
      endcase
   end

   always_comb begin
      next_flags       = '0;
      next_flags[SR_N] = cmd_valid & alu_result[WIDTH-1];
      next_flags[SR_Z] = cmd_valid & (alu_result == '0);
      next_flags[SR_C] = c_out;
      next_flags[SR_V] = v_out;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         status <= '0;
      end else if (s && !freeze) begin
         status <= next_flags;
      end
   end

   assign br_addr = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// ==========================================================================
// tb_exe_stage : directed and random checks of exe_stage against a model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst, freeze, mem_r_en, mem_w_en, s, imm;
   logic [3:0]  exe_cmd;
   logic [31:0] pc, val_rn, val_rm, mem_fwd, wb_fwd;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] alu_result, br_addr, st_val;
   logic [3:0]  status;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [3:0]  m_status = 4'b0000;

   exe_stage #(.WIDTH(32), .SR_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .freeze        (freeze),
      .exe_cmd       (exe_cmd),
      .mem_r_en      (mem_r_en),
      .mem_w_en      (mem_w_en),
      .s             (s),
      .imm           (imm),
      .pc            (pc),
      .val_rn        (val_rn),
      .val_rm        (val_rm),
      .shift_operand (shift_operand),
      .signed_imm_24 (signed_imm_24),
      .sel_src1      (sel_src1),
      .sel_src2      (sel_src2),
      .mem_fwd       (mem_fwd),
      .wb_fwd        (wb_fwd),
      .alu_result    (alu_result),
      .br_addr       (br_addr),
      .st_val        (st_val),
      .status        (status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] regv);
      if (sel == 2'd1) return mem_fwd;
      if (sel == 2'd2) return wb_fwd;
      return regv;
   endfunction

   function automatic logic [31:0] rot_right(input logic [31:0] x, input int n);
      logic [31:0] y;
      y = x;
      for (int k = 0; k < n; k++) y = {y[0], y[31:1]};
      return y;
   endfunction

   function automatic logic [31:0] m_val2();
      logic [31:0] rm;
      int          amt;
      rm  = m_fwd(sel_src2, val_rm);
      amt = int'(shift_operand[11:7]);
      if (mem_r_en || mem_w_en) return {20'b0, shift_operand};
      if (imm) return rot_right({24'b0, shift_operand[7:0]}, 2 * int'(shift_operand[11:8]));
      case (shift_operand[6:5])
         2'd0: return rm << amt;
         2'd1: return rm >> amt;
         2'd2: begin
            for (int k = 0; k < amt; k++) rm = {rm[31], rm[31:1]};
            return rm;
         end
         default: return rot_right(rm, amt);
      endcase
   endfunction

   // Returns {result, N, Z, C, V} computed with wide integer arithmetic
   function automatic logic [35:0] m_alu();
      logic [31:0] a, b, r;
      longint      ua, ub, u, sa, sb, sv;
      logic        c, v, cin;
      a   = m_fwd(sel_src1, val_rn);
      b   = m_val2();
      cin = m_status[1];
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      c   = cin;
      v   = 1'b0;
      u   = 0;
      sv  = 0;
      r   = 32'h0;
      case (exe_cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd2, 4'd3: begin
            u  = ua + ub + ((exe_cmd == 4'd3 && cin) ? 1 : 0);
            sv = sa + sb + ((exe_cmd == 4'd3 && cin) ? 1 : 0);
            r  = u[31:0];
            c  = (u >= 64'sh1_0000_0000);
            v  = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
         end
         4'd4, 4'd5: begin
            u  = ua - ub - ((exe_cmd == 4'd5 && !cin) ? 1 : 0);
            sv = sa - sb - ((exe_cmd == 4'd5 && !cin) ? 1 : 0);
            r  = u[31:0];
            c  = (u >= 0);
            v  = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
         end
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         default: return 36'h0;
      endcase
      return {r, r[31], (r == 32'h0), c, v};
   endfunction

   // Check combinational outputs, clock once, then check the status model
   task automatic step();
      logic [35:0] m;
      logic [31:0] br_exp;
      #1;
      m      = m_alu();
      br_exp = pc + (32'(signed'(signed_imm_24)) << 2);
      check("alu_result", alu_result, m[35:4]);
      check("br_addr", br_addr, br_exp);
      check("st_val", st_val, m_fwd(sel_src2, val_rm));
      @(posedge clk);
      if (!rst) m_status = 4'b0000;
      else if (s && !freeze) m_status = m[3:0];
      #1;
      check("status", {28'b0, status}, {28'b0, m_status});
   endtask

   task automatic clear_inputs();
      freeze = 0; exe_cmd = 0; mem_r_en = 0; mem_w_en = 0; s = 0; imm = 0;
      pc = 0; val_rn = 0; val_rm = 0; shift_operand = 0; signed_imm_24 = 0;
      sel_src1 = 0; sel_src2 = 0; mem_fwd = 0; wb_fwd = 0;
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset_status", {28'b0, status}, 32'h0);
      rst = 1'b1;

      // ADD overflow into the sign bit
      exe_cmd = 4'd2; val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; s = 1;
      #1 check("add_ovf_result", alu_result, 32'h8000_0000);
      step();
      check("add_ovf_flags", {28'b0, status}, 32'h9);

      // SUB equal operands
      clear_inputs();
      exe_cmd = 4'd4; val_rn = 5; val_rm = 5; s = 1;
      #1 check("sub_zero_result", alu_result, 32'h0);
      step();
      check("sub_zero_flags", {28'b0, status}, 32'h6);
      val_rn = 3; freeze = 1;
      step();
      check("freeze_hold", {28'b0, status}, 32'h6);

      // Rotated immediate and register ROR
      clear_inputs();
      exe_cmd = 4'd1; imm = 1; shift_operand = 12'hFFF;
      #1 check("mov_rot_imm", alu_result, 32'h0000_03FC);
      step();
      imm = 0; shift_operand = 12'h260; val_rm = 32'h0000_000F;
      #1 check("mov_ror4", alu_result, 32'hF000_0000);
      step();

      // Forwarding from both later stages
      clear_inputs();
      exe_cmd = 4'd2; sel_src1 = 2'd1; mem_fwd = 10; sel_src2 = 2'd2; wb_fwd = 3;
      #1 check("fwd_add", alu_result, 32'd13);
      check("fwd_st_val", st_val, 32'd3);
      step();

      // Backward branch and load offset
      clear_inputs();
      pc = 32'h100; signed_imm_24 = 24'hFFFFFF; exe_cmd = 4'd1; mem_r_en = 1;
      shift_operand = 12'h804; imm = 1;
      #1 check("br_back", br_addr, 32'h0000_00FC);
      check("ldr_val2", alu_result, 32'h0000_0804);
      step();

      for (int i = 0; i < 400; i++) begin
         rst           = ($urandom_range(0, 24) != 0);
         freeze        = ($urandom_range(0, 5) == 0);
         s             = $urandom_range(0, 1);
         exe_cmd       = 4'($urandom_range(0, 15));
         mem_r_en      = ($urandom_range(0, 7) == 0);
         mem_w_en      = ($urandom_range(0, 7) == 0);
         imm           = $urandom_range(0, 1);
         pc            = $urandom;
         val_rn        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
         val_rm        = ($urandom_range(0, 3) == 0) ? val_rn : $urandom;
         shift_operand = 12'($urandom);
         signed_imm_24 = 24'($urandom);
         sel_src1      = 2'($urandom_range(0, 3));
         sel_src2      = 2'($urandom_range(0, 3));
         mem_fwd       = $urandom;
         wb_fwd        = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
